// File: rtl/seg7_scan_display.sv
// Binary-to-BCD 7-segment scanner: capture on i_Valid&&o_Ready, o_Done at capture+INPUT_WIDTH+2, digits scanned every 2^SCAN_DIV_BITS clocks.
// Backpressure: o_Ready is low while converting; i_Valid is ignored then, nothing is queued.
module seg7_scan_display #(
  parameter int NUM_DIGITS    = 3,
  parameter int INPUT_WIDTH   = 13,
  parameter int SCAN_DIV_BITS = 16,
  parameter bit SIGNED        = 1'b0
) (
  input  logic                   Clk,
  input  logic                   i_Reset_n,
  input  logic [INPUT_WIDTH-1:0] i_Binary,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  output logic                   o_Done,
  input  logic                   i_Blank_Lz,
  input  logic [NUM_DIGITS-1:0]  i_DP,
  output logic [7:0]             SevenSegment,
  output logic [NUM_DIGITS-1:0]  Enable
);

  localparam int CAP   = SIGNED ? NUM_DIGITS - 1 : NUM_DIGITS;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(CAP);

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0001100;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;
  state_t state, state_nxt;

  logic [INPUT_WIDTH-1:0] bin_q, mag_q, mag_w;
  logic                   blank_q, neg_q, ovf_q, neg_w, ovf_w, capture, lz;
  logic [BCD_W-1:0]       bcd_q, bcd_adj;
  logic [CNT_W-1:0]       cnt_q;
  logic [6:0]             disp_q     [NUM_DIGITS];
  logic [6:0]             commit_seg [NUM_DIGITS];

  logic [SCAN_DIV_BITS-1:0] presc_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     tick;

  assign capture = i_Valid && o_Ready;

  always_ff @(posedge Clk) begin
    if (!i_Reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (capture) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt_q == CNT_W'(INPUT_WIDTH - 1)) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = capture ? S_LOAD : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_Ready = (state == S_IDLE) || (state == S_COMMIT);
    o_Done  = (state == S_COMMIT);
  end

  // Most-negative input negates to itself, which reads correctly as unsigned magnitude.
  always_comb begin
    neg_w = SIGNED && bin_q[INPUT_WIDTH-1];
    mag_w = neg_w ? (~bin_q + INPUT_WIDTH'(1)) : bin_q;
    ovf_w = 64'(mag_w) >= OVF_LIMIT;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // Walk MSD->LSD; lz stays set while every digit seen so far is zero.
  always_comb begin
    lz = blank_q;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      commit_seg[k] = digit_seg(bcd_q[4*k +: 4]);
      if (k >= CAP) begin
        commit_seg[k] = neg_q ? SEG_MINUS : SEG_BLANK;
      end else begin
        if (bcd_q[4*k +: 4] != 4'd0) lz = 1'b0;
        if (lz && k != 0) commit_seg[k] = SEG_BLANK;
      end
      if (ovf_q) commit_seg[k] = SEG_MINUS;
    end
  end

  always_ff @(posedge Clk) begin
    if (!i_Reset_n) begin
      bin_q   <= '0;
      blank_q <= 1'b0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= SEG_BLANK;
    end else begin
      if (capture) begin
        bin_q   <= i_Binary;
        blank_q <= i_Blank_Lz;
      end
      case (state)
        S_LOAD: begin
          mag_q <= mag_w;
          neg_q <= neg_w;
          ovf_q <= ovf_w;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        S_SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q          <= cnt_q + CNT_W'(1);
        end
        S_COMMIT: for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= commit_seg[k];
        default: ;
      endcase
    end
  end

  assign tick = &presc_q;

  always_ff @(posedge Clk) begin
    if (!i_Reset_n) begin
      presc_q      <= '0;
      idx_q        <= IDX_W'(NUM_DIGITS - 1);
      Enable       <= '1;
      SevenSegment <= 8'hFF;
    end else begin
      presc_q <= presc_q + SCAN_DIV_BITS'(1);
      if (tick) begin
        Enable       <= ~(NUM_DIGITS'(1) << idx_q);
        SevenSegment <= {disp_q[idx_q], ~i_DP[idx_q]};
        idx_q        <= (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: unsigned and signed instances share stimulus; table vectors,
// hand-written timing/reset sequences and random values checked against an arithmetic model.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] bin;
  logic        valid, blz;
  logic [2:0]  dp;
  logic        ready_u, done_u, ready_s, done_s;
  logic [7:0]  seg_u, seg_s;
  logic [2:0]  en_u, en_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(.NUM_DIGITS(3), .INPUT_WIDTH(13), .SCAN_DIV_BITS(2), .SIGNED(1'b0)) dut_u (
    .Clk(clk), .i_Reset_n(rst_n), .i_Binary(bin), .i_Valid(valid), .o_Ready(ready_u),
    .o_Done(done_u), .i_Blank_Lz(blz), .i_DP(dp), .SevenSegment(seg_u), .Enable(en_u));

  seg7_scan_display #(.NUM_DIGITS(3), .INPUT_WIDTH(13), .SCAN_DIV_BITS(2), .SIGNED(1'b1)) dut_s (
    .Clk(clk), .i_Reset_n(rst_n), .i_Binary(bin), .i_Valid(valid), .o_Ready(ready_s),
    .o_Done(done_s), .i_Blank_Lz(blz), .i_DP(dp), .SevenSegment(seg_s), .Enable(en_s));

  typedef struct packed {
    logic [12:0]     bin;
    logic            blz;
    logic [2:0]      dp;
    logic [2:0][6:0] eu;
    logic [2:0][6:0] es;
  } vec_t;

  vec_t       vt [10];
  logic [7:0] got_u [3];
  logic [7:0] got_s [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      default: return 7'b0001100;
    endcase
  endfunction

  // Expected {segments, dp} for digit k, straight from the value's decimal arithmetic.
  function automatic logic [7:0] model_byte(input logic [12:0] b, input logic bl,
                                            input logic [2:0] d, input bit sgn, input int k);
    int mag, cap;
    bit neg;
    logic [6:0] code;
    cap = sgn ? 2 : 3;
    neg = sgn && b[12];
    mag = neg ? 8192 - int'(b) : int'(b);
    if (mag >= p10(cap))                  code = 7'b1111110;
    else if (k >= cap)                    code = neg ? 7'b1111110 : 7'b1111111;
    else if (bl && k > 0 && mag < p10(k)) code = 7'b1111111;
    else                                  code = code_of((mag / p10(k)) % 10);
    return {code, ~d[k]};
  endfunction

  task automatic convert(input logic [12:0] b, input logic bl, input logic [2:0] d);
    int lat, ready_bad;
    bit seen;
    dp = d;
    chk("ready_before_capture", ready_u, 1);
    bin = b; blz = bl; valid = 1'b1;
    step();
    valid = 1'b0; bin = 13'($urandom); blz = ~bl;
    lat = 1; seen = 0; ready_bad = 0;
    while (lat < 40 && !seen) begin
      if (done_u) seen = 1;
      else begin
        if (ready_u || ready_s) ready_bad++;
        step();
        lat++;
      end
    end
    chk("done_latency", seen ? lat : 999, 15);
    chk("done_signed_inst", done_s, 1);
    chk("ready_at_commit", ready_u, 1);
    chk("ready_low_while_busy", ready_bad, 0);
    step();
    chk("done_one_cycle", done_u, 0);
  endtask

  task automatic read_display();
    int bad = 0;
    for (int k = 0; k < 3; k++) begin got_u[k] = 8'h00; got_s[k] = 8'h00; end
    repeat (5) step();
    repeat (12) begin
      step();
      case (en_u)
        3'b011: got_u[2] = seg_u;
        3'b101: got_u[1] = seg_u;
        3'b110: got_u[0] = seg_u;
        default: bad++;
      endcase
      case (en_s)
        3'b011: got_s[2] = seg_s;
        3'b101: got_s[1] = seg_s;
        3'b110: got_s[0] = seg_s;
        default: bad++;
      endcase
    end
    chk("enable_one_hot_low", bad, 0);
  endtask

  initial begin
    logic [2:0] seq_en [3];
    logic [7:0] seq_sg [3];
    logic [2:0] prev;
    int n, dones;

    vt[0] = {13'd500,    1'b0, 3'b000, 7'h24, 7'h01, 7'h01, 7'h7E, 7'h7E, 7'h7E};
    vt[1] = {13'd7,      1'b1, 3'b000, 7'h7F, 7'h7F, 7'h0F, 7'h7F, 7'h7F, 7'h0F};
    vt[2] = {13'd0,      1'b1, 3'b000, 7'h7F, 7'h7F, 7'h01, 7'h7F, 7'h7F, 7'h01};
    vt[3] = {13'd1000,   1'b0, 3'b000, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
    vt[4] = {13'h1FF3,   1'b0, 3'b000, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h4F, 7'h06};
    vt[5] = {13'h1000,   1'b0, 3'b000, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
    vt[6] = {13'd42,     1'b0, 3'b010, 7'h01, 7'h4C, 7'h12, 7'h7F, 7'h4C, 7'h12};
    vt[7] = {13'h1FFF,   1'b1, 3'b101, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7F, 7'h4F};
    vt[8] = {13'd99,     1'b1, 3'b100, 7'h7F, 7'h0C, 7'h0C, 7'h7F, 7'h0C, 7'h0C};
    vt[9] = {13'd5,      1'b0, 3'b001, 7'h01, 7'h01, 7'h24, 7'h7F, 7'h01, 7'h24};

    rst_n = 1'b0; bin = '0; valid = 1'b0; blz = 1'b0; dp = 3'b000;
    repeat (3) step();
    chk("reset_enable_u", en_u, 3'b111);
    chk("reset_seg_u", seg_u, 8'hFF);
    chk("reset_ready_u", ready_u, 1);
    chk("reset_done_u", done_u, 0);
    chk("reset_enable_s", en_s, 3'b111);
    chk("reset_seg_s", seg_s, 8'hFF);

    // First three scan ticks after reset: MSD first, all blank.
    rst_n = 1'b1;
    prev = en_u; n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      step();
      if (en_u != prev) begin
        seq_en[n] = en_u; seq_sg[n] = seg_u; prev = en_u; n++;
      end
    end
    chk("first_ticks_seen", n, 3);
    if (n == 3) begin
      chk("tick0_enable", seq_en[0], 3'b011);
      chk("tick1_enable", seq_en[1], 3'b101);
      chk("tick2_enable", seq_en[2], 3'b110);
      for (int k = 0; k < 3; k++) chk($sformatf("tick%0d_blank", k), seq_sg[k], 8'hFF);
    end

    for (int i = 0; i < 10; i++) begin
      convert(vt[i].bin, vt[i].blz, vt[i].dp);
      read_display();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("vec%0d_u_digit%0d", i, k), got_u[k], {vt[i].eu[k], ~vt[i].dp[k]});
        chk($sformatf("vec%0d_s_digit%0d", i, k), got_s[k], {vt[i].es[k], ~vt[i].dp[k]});
      end
    end

    // i_Valid pulsed while busy must be ignored.
    dp = 3'b000; bin = 13'd1000; blz = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0; dones = 0;
    for (int j = 1; j <= 40; j++) begin
      if (done_u) dones++;
      if (j == 3) begin valid = 1'b1; bin = 13'd5; end
      if (j == 6) valid = 1'b0;
      step();
    end
    chk("busy_valid_single_done", dones, 1);
    read_display();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy_u_digit%0d", k), got_u[k], 8'hFD);
      chk($sformatf("busy_s_digit%0d", k), got_s[k], 8'hFD);
    end

    // Reset at C+5 aborts the conversion and blanks the display.
    dp = 3'b010; bin = 13'd123; blz = 1'b0; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      if (done_u || done_s) dones++;
      step();
    end
    chk("abort_no_done", dones, 0);
    chk("abort_ready_u", ready_u, 1);
    chk("abort_ready_s", ready_s, 1);
    read_display();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_u_digit%0d", k), got_u[k], (k == 1) ? 8'hFE : 8'hFF);
      chk($sformatf("abort_s_digit%0d", k), got_s[k], (k == 1) ? 8'hFE : 8'hFF);
    end

    for (int i = 0; i < 30; i++) begin
      logic [12:0] rb;
      logic        rl;
      logic [2:0]  rd;
      case ($urandom_range(0, 3))
        0:       rb = 13'($urandom);
        1:       rb = 13'($urandom_range(0, 999));
        2:       rb = 13'(0 - int'($urandom_range(1, 99)));
        default: rb = 13'($urandom_range(0, 9));
      endcase
      rl = 1'($urandom_range(0, 1));
      rd = 3'($urandom);
      convert(rb, rl, rd);
      read_display();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_u_digit%0d bin=%0h", i, k, rb), got_u[k], model_byte(rb, rl, rd, 1'b0, k));
        chk($sformatf("rnd%0d_s_digit%0d bin=%0h", i, k, rb), got_s[k], model_byte(rb, rl, rd, 1'b1, k));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
